// File: rtl/pe_mlane_ws_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_mlane_ws_if                                                   |
// | Purpose  : Bundles the activation, partial-sum and weight-scratchpad        |
// |            signals of one multi-lane systolic PE.                           |
// | Modports : master - drives activations, partial sums and weight controls   |
// |            slave  - the PE itself                                            |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
interface pe_mlane_ws_if #(
  parameter int LANES              = 2,
  parameter int WMEM_ADDR_BITWIDTH = 8,
  parameter int ACT_BITWIDTH       = 8,
  parameter int WGT_BITWIDTH       = 8,
  parameter int SUM_IN_BITWIDTH    = 16,
  parameter int SUM_OUT_BITWIDTH   = 16
);
  logic [ACT_BITWIDTH-1:0]             act_in;
  logic                                act_valid_in;
  logic [LANES*SUM_IN_BITWIDTH-1:0]    sum_in;
  logic                                read_req_w_mem;
  logic [WMEM_ADDR_BITWIDTH-1:0]       r_addr_w_mem;
  logic                                write_req_w_mem;
  logic [WMEM_ADDR_BITWIDTH-1:0]       w_addr_w_mem;
  logic [LANES*WGT_BITWIDTH-1:0]       w_data_w_mem;
  logic                                ws_load;
  logic                                ws_release;
  logic                                ready;
  logic                                read_req_w_mem_frwrd;
  logic [WMEM_ADDR_BITWIDTH-1:0]       r_addr_w_mem_frwrd;
  logic [ACT_BITWIDTH-1:0]             act_out;
  logic                                act_valid_out;
  logic [LANES*SUM_OUT_BITWIDTH-1:0]   sum_out;
  logic                                sum_valid_out;
  logic [LANES-1:0]                    sat_flag;
  logic                                proto_err;

  modport master (
    output act_in, act_valid_in, sum_in, read_req_w_mem, r_addr_w_mem,
           write_req_w_mem, w_addr_w_mem, w_data_w_mem, ws_load, ws_release,
    input  ready, read_req_w_mem_frwrd, r_addr_w_mem_frwrd, act_out,
           act_valid_out, sum_out, sum_valid_out, sat_flag, proto_err
  );

  modport slave (
    input  act_in, act_valid_in, sum_in, read_req_w_mem, r_addr_w_mem,
           write_req_w_mem, w_addr_w_mem, w_data_w_mem, ws_load, ws_release,
    output ready, read_req_w_mem_frwrd, r_addr_w_mem_frwrd, act_out,
           act_valid_out, sum_out, sum_valid_out, sat_flag, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/pe_mlane_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_mlane_ws                                                      |
// | Purpose  : Multi-lane systolic PE. One activation is broadcast to LANES     |
// |            signed MACs; weights come from a local scratchpad every cycle    |
// |            (dynamic mode) or from a weight-stationary register (WS mode).   |
// | Ports    : clk   - clock                                                    |
// |            reset - asynchronous reset, active-low                           |
// |            bus   - pe_mlane_ws_if.slave: activations, partial sums, weight  |
// |                    scratchpad controls, forwarded signals, status flags     |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module pe_mlane_ws #(
  parameter int LANES              = 2,
  parameter int WMEM_ADDR_BITWIDTH = 8,
  parameter int ACT_BITWIDTH       = 8,
  parameter int WGT_BITWIDTH       = 8,
  parameter int SUM_IN_BITWIDTH    = 16,
  parameter int INTER_BITWIDTH     = 17,
  parameter int SUM_OUT_BITWIDTH   = 16,
  parameter     TRUNC_MODE         = "MSB",
  parameter int ACT_PIPELINE       = 1
) (
  input wire logic     clk,
  input wire logic     reset,
  pe_mlane_ws_if.slave bus
);
  localparam int c_DEPTH = 1 << WMEM_ADDR_BITWIDTH;
  localparam int c_WROW  = LANES * WGT_BITWIDTH;
  localparam int c_PROD  = ACT_BITWIDTH + WGT_BITWIDTH;
  localparam int c_SO    = SUM_OUT_BITWIDTH;

  typedef enum logic [1:0] {
    S_DYN     = 2'd0,
    S_WS_FILL = 2'd1,
    S_WS_HOLD = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [c_WROW-1:0]        r_wmem [c_DEPTH];
  logic [c_WROW-1:0]        r_rdata;
  logic [c_WROW-1:0]        r_ws;
  logic [LANES*c_SO-1:0]    r_sum;
  logic                     r_sum_valid;
  logic [LANES-1:0]         r_sat;
  logic                     r_proto;
  logic                     r_rreq_fw;
  logic [WMEM_ADDR_BITWIDTH-1:0] r_raddr_fw;

  logic                     w_ready, w_load_go, w_ws_capture, w_rd_en, w_accept;
  logic [c_WROW-1:0]        w_wgt_row;
  logic [LANES*c_SO-1:0]    w_sum_nxt;
  logic [LANES-1:0]         w_sat_hit;

  // ---------------- FSM next state / decode ----------------
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b1;
    w_load_go    = 1'b0;
    w_ws_capture = 1'b0;
    case (r_state)
      S_DYN: begin
        if (bus.ws_load) begin
          w_load_go   = 1'b1;
          w_state_nxt = S_WS_FILL;
        end
      end
      S_WS_FILL: begin
        // Scratchpad data requested by ws_load arrives this cycle.
        w_ready      = 1'b0;
        w_ws_capture = 1'b1;
        w_state_nxt  = S_WS_HOLD;
      end
      S_WS_HOLD: begin
        if (bus.ws_load) begin
          w_load_go   = 1'b1;
          w_state_nxt = S_WS_FILL;
        end else if (bus.ws_release) begin
          w_state_nxt = S_DYN;
        end
      end
      default: w_state_nxt = S_DYN;
    endcase
  end

  // ws_load forces a scratchpad read even without an external request.
  assign w_rd_en   = bus.read_req_w_mem | w_load_go;
  assign w_accept  = bus.act_valid_in & w_ready;
  assign w_wgt_row = (r_state == S_WS_HOLD) ? r_ws : r_rdata;

  // ---------------- Weight scratchpad (contents never reset) ----------------
  always_ff @(posedge clk) begin
    if (bus.write_req_w_mem) r_wmem[bus.w_addr_w_mem] <= bus.w_data_w_mem;
  end

  // Non-blocking update: a same-cycle write to the read address returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_rdata <= '0;
    else if (w_rd_en) r_rdata <= r_wmem[bus.r_addr_w_mem];
  end

  // ---------------- Per-lane MAC and truncation ----------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ACT_BITWIDTH-1:0]        w_act;
    logic [WGT_BITWIDTH-1:0]        w_wgt;
    logic [SUM_IN_BITWIDTH-1:0]     w_sin;
    logic signed [c_PROD-1:0]       w_act_x, w_wgt_x, w_prod;
    logic [INTER_BITWIDTH-1:0]      w_p;
    logic [c_SO-1:0]                w_trunc;
    logic                           w_unused_p;

    assign w_act   = bus.act_in;
    assign w_wgt   = w_wgt_row[gi*WGT_BITWIDTH +: WGT_BITWIDTH];
    assign w_sin   = bus.sum_in[gi*SUM_IN_BITWIDTH +: SUM_IN_BITWIDTH];
    assign w_act_x = {{WGT_BITWIDTH{w_act[ACT_BITWIDTH-1]}}, w_act};
    assign w_wgt_x = {{ACT_BITWIDTH{w_wgt[WGT_BITWIDTH-1]}}, w_wgt};
    assign w_prod  = w_act_x * w_wgt_x;
    assign w_p     = {{(INTER_BITWIDTH-c_PROD){w_prod[c_PROD-1]}}, w_prod}
                   + {{(INTER_BITWIDTH-SUM_IN_BITWIDTH){w_sin[SUM_IN_BITWIDTH-1]}}, w_sin};
    assign w_unused_p = ^w_p;

    if (TRUNC_MODE == "SAT") begin : g_sat
      logic w_ovf;
      // Overflow when the bits above the output sign bit are not a pure sign extension.
      assign w_ovf   = (w_p[INTER_BITWIDTH-1:c_SO-1] != {(INTER_BITWIDTH-c_SO+1){w_p[INTER_BITWIDTH-1]}});
      assign w_trunc = !w_ovf ? w_p[c_SO-1:0]
                     : (w_p[INTER_BITWIDTH-1] ? {1'b1, {(c_SO-1){1'b0}}} : {1'b0, {(c_SO-1){1'b1}}});
      assign w_sat_hit[gi] = w_ovf;
    end else if (TRUNC_MODE == "LSB") begin : g_lsb
      assign w_trunc       = w_p[c_SO-1:0];
      assign w_sat_hit[gi] = 1'b0;
    end else begin : g_msb
      assign w_trunc       = w_p[INTER_BITWIDTH-1 -: c_SO];
      assign w_sat_hit[gi] = 1'b0;
    end

    assign w_sum_nxt[gi*c_SO +: c_SO] = w_trunc;
  end

  // ---------------- State, WS register, outputs ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_DYN;
      r_ws        <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_sat       <= '0;
      r_proto     <= 1'b0;
      r_rreq_fw   <= 1'b0;
      r_raddr_fw  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sum_valid <= w_accept;
      r_rreq_fw   <= bus.read_req_w_mem;
      r_raddr_fw  <= bus.r_addr_w_mem;
      if (w_ws_capture) r_ws <= r_rdata;
      if (w_accept) begin
        r_sum <= w_sum_nxt;
        r_sat <= r_sat | w_sat_hit;
      end
      if (bus.act_valid_in && !w_ready) r_proto <= 1'b1;
    end
  end

  // ---------------- Activation forwarding ----------------
  if (ACT_PIPELINE != 0) begin : g_act_reg
    logic [ACT_BITWIDTH-1:0] r_act;
    logic                    r_act_valid;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_act       <= '0;
        r_act_valid <= 1'b0;
      end else begin
        r_act       <= bus.act_in;
        r_act_valid <= bus.act_valid_in;
      end
    end
    assign bus.act_out       = r_act;
    assign bus.act_valid_out = r_act_valid;
  end else begin : g_act_comb
    assign bus.act_out       = bus.act_in;
    assign bus.act_valid_out = bus.act_valid_in;
  end

  assign bus.ready                = w_ready;
  assign bus.read_req_w_mem_frwrd = r_rreq_fw;
  assign bus.r_addr_w_mem_frwrd   = r_raddr_fw;
  assign bus.sum_out              = r_sum;
  assign bus.sum_valid_out        = r_sum_valid;
  assign bus.sat_flag             = r_sat;
  assign bus.proto_err            = r_proto;
endmodule
`default_nettype wire

// File: tb/tb_pe_mlane_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pe_mlane_ws                                                   |
// | Purpose  : Directed self-checking bench for pe_mlane_ws.                    |
// |            u_dut_a : LSB truncation, SO=16, registered activation path      |
// |            u_dut_c : MSB truncation, same inputs as u_dut_a                 |
// |            u_dut_b : SAT truncation, SO=8, combinational activation path    |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pe_mlane_ws;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_mlane_ws_if #(.SUM_OUT_BITWIDTH(16)) ifa ();
  pe_mlane_ws_if #(.SUM_OUT_BITWIDTH(16)) ifc ();
  pe_mlane_ws_if #(.SUM_OUT_BITWIDTH(8))  ifb ();

  pe_mlane_ws #(.TRUNC_MODE("LSB"), .SUM_OUT_BITWIDTH(16), .ACT_PIPELINE(1))
    u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pe_mlane_ws #(.TRUNC_MODE("MSB"), .SUM_OUT_BITWIDTH(16), .ACT_PIPELINE(1))
    u_dut_c (.clk(clk), .reset(reset), .bus(ifc));
  pe_mlane_ws #(.TRUNC_MODE("SAT"), .SUM_OUT_BITWIDTH(8), .ACT_PIPELINE(0))
    u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifc.act_in          = ifa.act_in;
  assign ifc.act_valid_in    = ifa.act_valid_in;
  assign ifc.sum_in          = ifa.sum_in;
  assign ifc.read_req_w_mem  = ifa.read_req_w_mem;
  assign ifc.r_addr_w_mem    = ifa.r_addr_w_mem;
  assign ifc.write_req_w_mem = ifa.write_req_w_mem;
  assign ifc.w_addr_w_mem    = ifa.w_addr_w_mem;
  assign ifc.w_data_w_mem    = ifa.w_data_w_mem;
  assign ifc.ws_load         = ifa.ws_load;
  assign ifc.ws_release      = ifa.ws_release;

  typedef struct {
    logic [7:0]         addr;
    logic signed [7:0]  w0, w1, act;
    logic signed [15:0] s0, s1;
    logic signed [15:0] e0, e1;   // LSB results
    logic signed [15:0] m0, m1;   // MSB results
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.act_in = '0; ifa.act_valid_in = 1'b0; ifa.sum_in = '0;
    ifa.read_req_w_mem = 1'b0; ifa.r_addr_w_mem = '0;
    ifa.write_req_w_mem = 1'b0; ifa.w_addr_w_mem = '0; ifa.w_data_w_mem = '0;
    ifa.ws_load = 1'b0; ifa.ws_release = 1'b0;
  endtask

  task automatic idle_b();
    ifb.act_in = '0; ifb.act_valid_in = 1'b0; ifb.sum_in = '0;
    ifb.read_req_w_mem = 1'b0; ifb.r_addr_w_mem = '0;
    ifb.write_req_w_mem = 1'b0; ifb.w_addr_w_mem = '0; ifb.w_data_w_mem = '0;
    ifb.ws_load = 1'b0; ifb.ws_release = 1'b0;
  endtask

  initial begin
    vt[0] = '{addr:8'd3,   w0:8'sd5,   w1:-8'sd2,  act:8'sd7,  s0:-16'sd10,  s1:16'sd100,
              e0:16'sd25,    e1:16'sd86,     m0:16'sd12,     m1:16'sd43};
    vt[1] = '{addr:8'd7,   w0:-8'sd4,  w1:8'sd3,   act:-8'sd5, s0:16'sd50,   s1:16'sd0,
              e0:16'sd70,    e1:-16'sd15,    m0:16'sd35,     m1:-16'sd8};
    vt[2] = '{addr:8'hFF,  w0:8'sd127, w1:8'h80,   act:8'h80,  s0:16'h8000,  s1:16'sd32767,
              e0:16'sd16512, e1:-16'sd16385, m0:-16'sd24512, m1:16'sd24575};
    vt[3] = '{addr:8'd0,   w0:8'sd1,   w1:8'sd1,   act:8'sd0,  s0:-16'sd1,   s1:16'sd1,
              e0:-16'sd1,    e1:16'sd1,      m0:-16'sd1,     m1:16'sd0};

    reset = 1'b0;
    idle_a();
    idle_b();
    tick(); tick();
    chk("rst_sum_out_a",   ifa.sum_out,              0);
    chk("rst_sum_valid_a", ifa.sum_valid_out,        0);
    chk("rst_act_out_a",   ifa.act_out,              0);
    chk("rst_proto_a",     ifa.proto_err,            0);
    chk("rst_frwrd_a",     ifa.read_req_w_mem_frwrd, 0);
    chk("rst_sat_b",       ifb.sat_flag,             0);
    reset = 1'b1;
    tick();
    chk("ready_dyn_a", ifa.ready, 1);

    // ---- Dynamic-mode MAC vectors (first entry is the basic dynamic case) ----
    for (int i = 0; i < 4; i++) begin
      ifa.write_req_w_mem = 1'b1; ifa.w_addr_w_mem = vt[i].addr;
      ifa.w_data_w_mem = {vt[i].w1, vt[i].w0};
      tick();
      ifa.write_req_w_mem = 1'b0;
      ifa.read_req_w_mem = 1'b1; ifa.r_addr_w_mem = vt[i].addr;
      tick();
      ifa.read_req_w_mem = 1'b0;
      ifa.act_valid_in = 1'b1; ifa.act_in = vt[i].act; ifa.sum_in = {vt[i].s1, vt[i].s0};
      tick();
      ifa.act_valid_in = 1'b0;
      chk($sformatf("vec%0d_lsb_l0", i), $signed(ifa.sum_out[15:0]),  vt[i].e0);
      chk($sformatf("vec%0d_lsb_l1", i), $signed(ifa.sum_out[31:16]), vt[i].e1);
      chk($sformatf("vec%0d_msb_l0", i), $signed(ifc.sum_out[15:0]),  vt[i].m0);
      chk($sformatf("vec%0d_msb_l1", i), $signed(ifc.sum_out[31:16]), vt[i].m1);
      chk($sformatf("vec%0d_valid",  i), ifa.sum_valid_out, 1);
      tick();
      chk($sformatf("vec%0d_valid_drop", i), ifa.sum_valid_out, 0);
      chk($sformatf("vec%0d_hold",       i), $signed(ifa.sum_out[15:0]), vt[i].e0);
    end

    // ---- WS mode: weights latched, scratchpad overwritten afterwards ----
    ifa.ws_load = 1'b1; ifa.r_addr_w_mem = 8'd3;
    tick();
    ifa.ws_load = 1'b0;
    chk("ws_fill_ready", ifa.ready, 0);
    ifa.write_req_w_mem = 1'b1; ifa.w_addr_w_mem = 8'd3; ifa.w_data_w_mem = '0;
    tick();
    ifa.write_req_w_mem = 1'b0;
    chk("ws_hold_ready", ifa.ready, 1);
    for (int k = 1; k <= 3; k++) begin
      ifa.act_valid_in = 1'b1; ifa.act_in = 8'(k); ifa.sum_in = '0;
      tick();
      chk($sformatf("ws_act%0d_l0", k), $signed(ifa.sum_out[15:0]),  5 * k);
      chk($sformatf("ws_act%0d_l1", k), $signed(ifa.sum_out[31:16]), -2 * k);
    end
    ifa.act_valid_in = 1'b0;
    ifa.ws_release = 1'b1;
    tick();
    ifa.ws_release = 1'b0;
    ifa.read_req_w_mem = 1'b1; ifa.r_addr_w_mem = 8'd3;
    tick();
    ifa.read_req_w_mem = 1'b0;
    ifa.act_valid_in = 1'b1; ifa.act_in = 8'sd5; ifa.sum_in = {16'sd9, 16'sd7};
    tick();
    ifa.act_valid_in = 1'b0;
    chk("release_l0", $signed(ifa.sum_out[15:0]),  7);
    chk("release_l1", $signed(ifa.sum_out[31:16]), 9);
    chk("proto_clean", ifa.proto_err, 0);

    // ---- WS_FILL window: one not-ready cycle, rejected valid ----
    ifa.write_req_w_mem = 1'b1; ifa.w_addr_w_mem = 8'd4; ifa.w_data_w_mem = {8'sd1, 8'sd2};
    tick();
    ifa.write_req_w_mem = 1'b0;
    ifa.ws_load = 1'b1; ifa.r_addr_w_mem = 8'd4;
    tick();
    ifa.ws_load = 1'b0;
    chk("fill_ready", ifa.ready, 0);
    ifa.act_valid_in = 1'b1; ifa.act_in = 8'd33; ifa.sum_in = '0;
    tick();
    ifa.act_valid_in = 1'b0;
    chk("fill_no_valid",  ifa.sum_valid_out, 0);
    chk("fill_proto",     ifa.proto_err,     1);
    chk("fill_act_out",   ifa.act_out,       33);
    chk("fill_act_vout",  ifa.act_valid_out, 1);
    chk("fill_ready_ret", ifa.ready,         1);
    ifa.ws_load = 1'b1; ifa.ws_release = 1'b1;
    tick();
    ifa.ws_load = 1'b0; ifa.ws_release = 1'b0;
    chk("load_wins_ready", ifa.ready, 0);
    tick();
    chk("reload_hold_ready", ifa.ready, 1);
    ifa.act_valid_in = 1'b1; ifa.act_in = 8'sd2; ifa.sum_in = '0;
    tick();
    ifa.act_valid_in = 1'b0;
    chk("reload_l0", $signed(ifa.sum_out[15:0]),  4);
    chk("reload_l1", $signed(ifa.sum_out[31:16]), 2);
    ifa.ws_release = 1'b1;
    tick();
    ifa.ws_release = 1'b0;

    // ---- Forwarding latency on the registered-activation PE ----
    ifa.act_in = 8'd11;
    tick();
    ifa.act_in = 8'd66;
    #1;
    chk("a_act_lat_before", ifa.act_out, 11);
    tick();
    chk("a_act_lat_after", ifa.act_out, 66);
    ifa.read_req_w_mem = 1'b1; ifa.r_addr_w_mem = 8'h5A;
    #1;
    chk("a_frwrd_before", ifa.read_req_w_mem_frwrd, 0);
    tick();
    ifa.read_req_w_mem = 1'b0;
    chk("a_frwrd_req",  ifa.read_req_w_mem_frwrd, 1);
    chk("a_frwrd_addr", ifa.r_addr_w_mem_frwrd, 8'h5A);

    // ---- SAT lanes on u_dut_b (SO=8, combinational activation path) ----
    ifb.write_req_w_mem = 1'b1; ifb.w_addr_w_mem = 8'd1; ifb.w_data_w_mem = {8'sd1, 8'sd127};
    tick();
    ifb.write_req_w_mem = 1'b0;
    ifb.read_req_w_mem = 1'b1; ifb.r_addr_w_mem = 8'd1;
    #1;
    chk("b_frwrd_before", ifb.read_req_w_mem_frwrd, 0);
    tick();
    ifb.read_req_w_mem = 1'b0;
    chk("b_frwrd_req",  ifb.read_req_w_mem_frwrd, 1);
    chk("b_frwrd_addr", ifb.r_addr_w_mem_frwrd, 1);
    ifb.act_valid_in = 1'b1; ifb.act_in = 8'sd127; ifb.sum_in = '0;
    #1;
    chk("b_act_comb",   ifb.act_out,       127);
    chk("b_avalid_comb", ifb.act_valid_out, 1);
    tick();
    chk("sat_pos_l0", $signed(ifb.sum_out[7:0]),  127);
    chk("sat_pos_l1", $signed(ifb.sum_out[15:8]), 127);
    chk("sat_flag_1", ifb.sat_flag, 1);
    ifb.act_in = 8'h80; ifb.sum_in = {-16'sd1, 16'sd0};
    tick();
    chk("sat_neg_l0", $signed(ifb.sum_out[7:0]),  -128);
    chk("sat_neg_l1", $signed(ifb.sum_out[15:8]), -128);
    chk("sat_flag_2", ifb.sat_flag, 3);
    ifb.act_in = 8'sd3; ifb.sum_in = {-16'sd20, -16'sd400};
    tick();
    ifb.act_valid_in = 1'b0;
    chk("sat_in_l0",  $signed(ifb.sum_out[7:0]),  -19);
    chk("sat_in_l1",  $signed(ifb.sum_out[15:8]), -17);
    chk("sat_sticky", ifb.sat_flag, 3);

    // ---- Same-cycle write/read returns old data ----
    ifb.write_req_w_mem = 1'b1; ifb.w_addr_w_mem = 8'd2; ifb.w_data_w_mem = {8'sd2, 8'sd3};
    tick();
    ifb.w_data_w_mem = {8'sd9, 8'sd9};
    ifb.read_req_w_mem = 1'b1; ifb.r_addr_w_mem = 8'd2;
    tick();
    ifb.write_req_w_mem = 1'b0; ifb.read_req_w_mem = 1'b0;
    ifb.act_valid_in = 1'b1; ifb.act_in = 8'sd1; ifb.sum_in = '0;
    tick();
    ifb.act_valid_in = 1'b0;
    chk("rw_old_l0", $signed(ifb.sum_out[7:0]),  3);
    chk("rw_old_l1", $signed(ifb.sum_out[15:8]), 2);
    ifb.read_req_w_mem = 1'b1;
    tick();
    ifb.read_req_w_mem = 1'b0;
    ifb.act_valid_in = 1'b1;
    tick();
    ifb.act_valid_in = 1'b0;
    chk("rw_new_l0", $signed(ifb.sum_out[7:0]), 9);

    // ---- Asynchronous reset during WS_FILL with a valid in flight ----
    ifa.read_req_w_mem = 1'b1; ifa.r_addr_w_mem = 8'd4;
    ifa.ws_load = 1'b1;
    tick();
    ifa.ws_load = 1'b0;
    ifa.act_valid_in = 1'b1; ifa.act_in = 8'd9;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_sum_out",   ifa.sum_out,              0);
    chk("arst_sum_valid", ifa.sum_valid_out,        0);
    chk("arst_act_out",   ifa.act_out,              0);
    chk("arst_act_vout",  ifa.act_valid_out,        0);
    chk("arst_proto",     ifa.proto_err,            0);
    chk("arst_frwrd",     ifa.read_req_w_mem_frwrd, 0);
    chk("arst_frwrd_addr", ifa.r_addr_w_mem_frwrd,  0);
    chk("arst_sum_c",     ifc.sum_out,              0);
    chk("arst_sat_b",     ifb.sat_flag,             0);
    idle_a();
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_ready", ifa.ready, 1);
    ifa.read_req_w_mem = 1'b1; ifa.r_addr_w_mem = 8'd4;
    tick();
    ifa.read_req_w_mem = 1'b0;
    ifa.act_valid_in = 1'b1; ifa.act_in = 8'sd3; ifa.sum_in = '0;
    tick();
    ifa.act_valid_in = 1'b0;
    chk("retain_l0", $signed(ifa.sum_out[15:0]),  6);
    chk("retain_l1", $signed(ifa.sum_out[31:16]), 3);
    chk("retain_valid", ifa.sum_valid_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
